// File: rtl/adc_capture_sequencer.sv
// adc_capture_sequencer: arm/trigger sequencer that snapshots NCHAN ADC streams into readout buffers.
// Latency: a beat sampled in CAPTURE appears on buf_* one aclk later, so trig to first write is 2 cycles in async mode.
// Backpressure: none toward the ADCs; a beat is taken only when every enabled tvalid is high, and gaps stretch the capture.
module adc_capture_sequencer #(
  parameter int NCHAN     = 4,
  parameter int DATA_W    = 128,
  parameter int ADDR_BITS = 11
) (
  input  logic                     aclk,
  input  logic                     aresetn,
  input  logic                     arm_i,
  input  logic                     abort_i,
  input  logic                     trig_i,
  input  logic                     sysref_i,
  input  logic                     sync_mode_i,
  input  logic [NCHAN-1:0]         chan_en_i,
  input  logic [ADDR_BITS:0]       length_i,
  input  logic [NCHAN*DATA_W-1:0]  s_axis_tdata,
  input  logic [NCHAN-1:0]         s_axis_tvalid,
  output logic [NCHAN*DATA_W-1:0]  buf_tdata_o,
  output logic [NCHAN-1:0]         buf_we_o,
  output logic [ADDR_BITS-1:0]     buf_addr_o,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     gap_err_o,
  output logic                     len_err_o,
  output logic [ADDR_BITS:0]       count_o
);

  localparam int                LEN_W   = ADDR_BITS + 1;
  // Largest legal capture: the whole buffer depth.
  localparam logic [LEN_W-1:0]  MAX_LEN = {1'b1, {ADDR_BITS{1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_ARMED     = 3'd1,
    S_SYNC_WAIT = 3'd2,
    S_CAPTURE   = 3'd3,
    S_DONE      = 3'd4
  } state_t;

  state_t             state;
  logic               sysref_q;
  logic [NCHAN-1:0]   en_lat;
  logic [LEN_W-1:0]   len_lat;
  logic               sync_lat;

  logic               sysref_edge;
  logic               valid_all;
  logic               len_ok;
  logic               beat_ok;
  logic               last_beat;

  // Only a fresh rising edge counts; a SYSREF already high at trigger time is ignored.
  assign sysref_edge = sysref_i & ~sysref_q;
  // Disabled channels never hold a beat back.
  assign valid_all   = &(s_axis_tvalid | ~en_lat);
  assign len_ok      = (length_i != '0) && (length_i <= MAX_LEN);
  // An empty enable mask must never write, even though valid_all is trivially true.
  assign beat_ok     = (state == S_CAPTURE) && valid_all && (|en_lat);
  // count_o is the pre-increment address of the beat being taken now.
  assign last_beat   = ((count_o + LEN_W'(1)) == len_lat);

  // SYSREF history, tracked in every state so edge detection is valid on SYNC_WAIT entry.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      sysref_q <= 1'b0;
    end else begin
      sysref_q <= sysref_i;
    end
  end

  // Sequencer FSM with all outputs registered; abort beats arm, arm beats trigger.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state       <= S_IDLE;
      en_lat      <= '0;
      len_lat     <= '0;
      sync_lat    <= 1'b0;
      buf_tdata_o <= '0;
      buf_we_o    <= '0;
      buf_addr_o  <= '0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      gap_err_o   <= 1'b0;
      len_err_o   <= 1'b0;
      count_o     <= '0;
    end else begin
      buf_we_o <= '0;
      if (abort_i) begin
        // Any beat sampled this cycle is dropped; count_o keeps what was written.
        state  <= S_IDLE;
        busy_o <= 1'b0;
        done_o <= 1'b0;
      end else begin
        case (state)
          S_IDLE, S_DONE: begin
            if (arm_i) begin
              if (len_ok) begin
                en_lat    <= chan_en_i;
                len_lat   <= length_i;
                sync_lat  <= sync_mode_i;
                done_o    <= 1'b0;
                gap_err_o <= 1'b0;
                len_err_o <= 1'b0;
                count_o   <= '0;
                busy_o    <= 1'b1;
                state     <= S_ARMED;
              end else begin
                len_err_o <= 1'b1;
              end
            end
          end
          S_ARMED: begin
            if (trig_i) begin
              state <= sync_lat ? S_SYNC_WAIT : S_CAPTURE;
            end
          end
          S_SYNC_WAIT: begin
            if (sysref_edge) begin
              state <= S_CAPTURE;
            end
          end
          S_CAPTURE: begin
            if (beat_ok) begin
              buf_we_o    <= en_lat;
              buf_tdata_o <= s_axis_tdata;
              buf_addr_o  <= count_o[ADDR_BITS-1:0];
              count_o     <= count_o + LEN_W'(1);
              if (last_beat) begin
                state  <= S_DONE;
                busy_o <= 1'b0;
                done_o <= 1'b1;
              end
            end else if (|en_lat) begin
              gap_err_o <= 1'b1;
            end
          end
          default: begin
            state  <= S_IDLE;
            busy_o <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_adc_capture_sequencer.sv
// tb_adc_capture_sequencer: directed-vector bench for the ADC capture sequencer.
// Latency: inputs change and outputs are sampled 1 ns after each rising aclk edge.
// Backpressure: tvalid gaps are driven directly from per-cycle vectors.
module tb_adc_capture_sequencer;

  localparam int NCHAN     = 4;
  localparam int DATA_W    = 128;
  localparam int ADDR_BITS = 11;
  localparam int TW        = NCHAN * DATA_W;

  logic                   aclk = 1'b0;
  logic                   aresetn;
  logic                   arm_i;
  logic                   abort_i;
  logic                   trig_i;
  logic                   sysref_i;
  logic                   sync_mode_i;
  logic [NCHAN-1:0]       chan_en_i;
  logic [ADDR_BITS:0]     length_i;
  logic [TW-1:0]          s_axis_tdata;
  logic [NCHAN-1:0]       s_axis_tvalid;
  logic [TW-1:0]          buf_tdata_o;
  logic [NCHAN-1:0]       buf_we_o;
  logic [ADDR_BITS-1:0]   buf_addr_o;
  logic                   busy_o;
  logic                   done_o;
  logic                   gap_err_o;
  logic                   len_err_o;
  logic [ADDR_BITS:0]     count_o;

  logic [TW-1:0]          prev_dat;
  int                     n_vec  = 0;
  int                     n_miss = 0;
  int                     cyc    = 0;
  int                     nwr;
  int                     ea;
  logic                   is_wr;

  adc_capture_sequencer #(
    .NCHAN     (NCHAN),
    .DATA_W    (DATA_W),
    .ADDR_BITS (ADDR_BITS)
  ) dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .arm_i         (arm_i),
    .abort_i       (abort_i),
    .trig_i        (trig_i),
    .sysref_i      (sysref_i),
    .sync_mode_i   (sync_mode_i),
    .chan_en_i     (chan_en_i),
    .length_i      (length_i),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .buf_tdata_o   (buf_tdata_o),
    .buf_we_o      (buf_we_o),
    .buf_addr_o    (buf_addr_o),
    .busy_o        (busy_o),
    .done_o        (done_o),
    .gap_err_o     (gap_err_o),
    .len_err_o     (len_err_o),
    .count_o       (count_o)
  );

  always #5 aclk = ~aclk;

  // Distinct pattern per channel lane and per cycle.
  function automatic logic [TW-1:0] mk_data(input int c);
    logic [TW-1:0] d;
    d = '0;
    for (int ch = 0; ch < NCHAN; ch++) begin
      d[ch*DATA_W +: DATA_W] = DATA_W'({32'hA500_0000 | 32'(ch), 32'(c), ~32'(c), 32'(c * 7 + ch)});
    end
    return d;
  endfunction

  task automatic check(input string tag, input logic [TW-1:0] got, input logic [TW-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one cycle; remember the data the DUT sampled on this edge.
  task automatic step();
    prev_dat = s_axis_tdata;
    @(posedge aclk);
    #1;
    cyc++;
    s_axis_tdata = mk_data(cyc);
  endtask

  task automatic chk_zero(input string pfx);
    check({pfx, "_we"},    TW'(buf_we_o),    TW'(0));
    check({pfx, "_addr"},  TW'(buf_addr_o),  TW'(0));
    check({pfx, "_dat"},   buf_tdata_o,      TW'(0));
    check({pfx, "_busy"},  TW'(busy_o),      TW'(0));
    check({pfx, "_done"},  TW'(done_o),      TW'(0));
    check({pfx, "_gap"},   TW'(gap_err_o),   TW'(0));
    check({pfx, "_lerr"},  TW'(len_err_o),   TW'(0));
    check({pfx, "_count"}, TW'(count_o),     TW'(0));
  endtask

  initial begin
    aresetn       = 1'b0;
    arm_i         = 1'b0;
    abort_i       = 1'b0;
    trig_i        = 1'b0;
    sysref_i      = 1'b0;
    sync_mode_i   = 1'b0;
    chan_en_i     = '0;
    length_i      = '0;
    s_axis_tvalid = '1;
    s_axis_tdata  = mk_data(0);
    prev_dat      = '0;

    // Reset state
    step();
    step();
    chk_zero("rst");
    aresetn = 1'b1;
    step();

    // Async mode, 16 beats, all channels
    arm_i = 1'b1; length_i = 12'd16; chan_en_i = 4'hF; sync_mode_i = 1'b0;
    step();
    arm_i = 1'b0;
    check("t1_armed_busy", TW'(busy_o), TW'(1));
    trig_i = 1'b1;
    step();
    trig_i = 1'b0;
    for (int k = 1; k <= 19; k++) begin
      if (k >= 2 && k <= 17) begin
        check("t1_we",   TW'(buf_we_o),   TW'(4'hF));
        check("t1_addr", TW'(buf_addr_o), TW'(k - 2));
        check("t1_dat",  buf_tdata_o,     prev_dat);
      end else begin
        check("t1_we_off", TW'(buf_we_o), TW'(0));
      end
      if (k == 18) begin
        check("t1_done",  TW'(done_o),  TW'(1));
        check("t1_count", TW'(count_o), TW'(16));
        check("t1_busy",  TW'(busy_o),  TW'(0));
      end
      step();
    end

    // Sync mode: SYSREF high at trigger, low T+3..T+9, rises at T+10
    sysref_i = 1'b1;
    step();
    arm_i = 1'b1; length_i = 12'd4; chan_en_i = 4'hF; sync_mode_i = 1'b1;
    step();
    arm_i = 1'b0;
    check("t2_done_clr", TW'(done_o), TW'(0));
    trig_i = 1'b1;
    step();
    trig_i = 1'b0;
    for (int k = 1; k <= 17; k++) begin
      sysref_i = (k < 3 || k >= 10);
      if (k >= 12 && k <= 15) begin
        check("t2_we",   TW'(buf_we_o),   TW'(4'hF));
        check("t2_addr", TW'(buf_addr_o), TW'(k - 12));
      end else begin
        check("t2_we_off", TW'(buf_we_o), TW'(0));
      end
      if (k == 16) begin
        check("t2_done",  TW'(done_o),  TW'(1));
        check("t2_count", TW'(count_o), TW'(4));
      end
      step();
    end
    sysref_i = 1'b0;

    // Channels 0 and 2, 8 beats, tvalid[0] low for 3 cycles
    arm_i = 1'b1; length_i = 12'd8; chan_en_i = 4'b0101; sync_mode_i = 1'b0;
    step();
    arm_i = 1'b0;
    trig_i = 1'b1;
    step();
    trig_i = 1'b0;
    ea = 0;
    for (int k = 1; k <= 14; k++) begin
      s_axis_tvalid = (k >= 4 && k <= 6) ? 4'b0100 : 4'b0101;
      is_wr = (k >= 2 && k <= 4) || (k >= 8 && k <= 12);
      if (k == 1) check("t3_gap_clr", TW'(gap_err_o), TW'(0));
      if (is_wr) begin
        check("t3_we",   TW'(buf_we_o),   TW'(4'b0101));
        check("t3_addr", TW'(buf_addr_o), TW'(ea));
        check("t3_dat",  buf_tdata_o,     prev_dat);
        ea++;
      end else begin
        check("t3_we_off", TW'(buf_we_o), TW'(0));
      end
      if (k == 13) begin
        check("t3_gap",   TW'(gap_err_o), TW'(1));
        check("t3_count", TW'(count_o),   TW'(8));
        check("t3_done",  TW'(done_o),    TW'(1));
      end
      step();
    end
    s_axis_tvalid = '1;

    // Abort during the cycle the 5th write is visible, length 32
    arm_i = 1'b1; length_i = 12'd32; chan_en_i = 4'hF;
    step();
    arm_i = 1'b0;
    check("t4_gap_clr", TW'(gap_err_o), TW'(0));
    trig_i = 1'b1;
    step();
    trig_i = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      abort_i = (k == 6);
      if (k >= 2 && k <= 6) begin
        check("t4_we",   TW'(buf_we_o),   TW'(4'hF));
        check("t4_addr", TW'(buf_addr_o), TW'(k - 2));
      end else begin
        check("t4_we_off", TW'(buf_we_o), TW'(0));
      end
      if (k >= 7) begin
        check("t4_busy",  TW'(busy_o),  TW'(0));
        check("t4_done",  TW'(done_o),  TW'(0));
        check("t4_count", TW'(count_o), TW'(5));
      end
      step();
    end
    abort_i = 1'b0;
    arm_i = 1'b1; length_i = 12'd4;
    step();
    arm_i = 1'b0;
    trig_i = 1'b1;
    step();
    trig_i = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      if (k >= 2 && k <= 5) begin
        check("t4r_we",   TW'(buf_we_o),   TW'(4'hF));
        check("t4r_addr", TW'(buf_addr_o), TW'(k - 2));
      end
      if (k == 6) begin
        check("t4r_done",  TW'(done_o),  TW'(1));
        check("t4r_count", TW'(count_o), TW'(4));
      end
      step();
    end

    // Length legality and full-depth capture
    abort_i = 1'b1;
    step();
    abort_i = 1'b0;
    check("t5_abort_done", TW'(done_o), TW'(0));
    arm_i = 1'b1; length_i = 12'd0;
    step();
    arm_i = 1'b0;
    check("t5_len0_err",  TW'(len_err_o), TW'(1));
    check("t5_len0_busy", TW'(busy_o),    TW'(0));
    arm_i = 1'b1; length_i = 12'd2049;
    step();
    arm_i = 1'b0;
    check("t5_len2049_err",  TW'(len_err_o), TW'(1));
    check("t5_len2049_busy", TW'(busy_o),    TW'(0));
    trig_i = 1'b1;
    step();
    trig_i = 1'b0;
    check("t5_trig_idle_we", TW'(buf_we_o), TW'(0));
    arm_i = 1'b1; length_i = 12'd2048;
    step();
    arm_i = 1'b0;
    check("t5_len_ok_err",  TW'(len_err_o), TW'(0));
    check("t5_len_ok_busy", TW'(busy_o),    TW'(1));
    trig_i = 1'b1;
    step();
    trig_i = 1'b0;
    nwr = 0;
    for (int k = 1; k <= 2052; k++) begin
      if (buf_we_o != '0) begin
        check("t5_we",   TW'(buf_we_o),   TW'(4'hF));
        check("t5_addr", TW'(buf_addr_o), TW'(nwr));
        nwr++;
      end
      step();
    end
    check("t5_nwr",   TW'(nwr),     TW'(2048));
    check("t5_done",  TW'(done_o),  TW'(1));
    check("t5_count", TW'(count_o), TW'(2048));

    // Asynchronous reset in the middle of a capture
    arm_i = 1'b1; length_i = 12'd16;
    step();
    arm_i = 1'b0;
    trig_i = 1'b1;
    step();
    trig_i = 1'b0;
    for (int k = 1; k < 5; k++) step();
    check("t6_pre_we", TW'(buf_we_o), TW'(4'hF));
    #2;
    aresetn = 1'b0;
    #1;
    chk_zero("t6");
    step();
    step();
    aresetn = 1'b1;
    step();
    trig_i = 1'b1;
    step();
    trig_i = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      check("t6_we",   TW'(buf_we_o), TW'(0));
      check("t6_busy", TW'(busy_o),   TW'(0));
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/adc_capture_sequencer.md
Name: adc_capture_sequencer

Overview:
Sequences snapshot captures from the four ADC AXI4-Streams into the readout buffers. It is armed by software, fires on a trigger that is either immediate or aligned to the next SYSREF edge, and writes exactly length_i beats per enabled channel. It emits a per-channel write strobe and a shared address. It sits between the adcN_ streams and the bufN_ stores inside the design, in the aclk domain.

Parameters:
NCHAN, 4, number of ADC channels.
DATA_W, 128, tdata width per channel.
ADDR_BITS, 11, buffer address width; depth is 2^ADDR_BITS beats.

Ports:
aclk  in  1  stream clock, 375 MHz.
aresetn  in  1  asynchronous active-low reset.
arm_i  in  1  single-cycle pulse: arm a capture.
abort_i  in  1  single-cycle pulse: abandon the current capture.
trig_i  in  1  single-cycle pulse: trigger.
sysref_i  in  1  SYSREF, already synchronous to aclk.
sync_mode_i  in  1  1 = start on the first SYSREF rising edge after trigger; 0 = start immediately.
chan_en_i  in  NCHAN  channel enable mask.
length_i  in  ADDR_BITS+1  beats to capture; legal range 1..2^ADDR_BITS.
s_axis_tdata  in  NCHAN*DATA_W  concatenated ADC data; channel 0 in the LSBs.
s_axis_tvalid  in  NCHAN  per-channel valid.
buf_tdata_o  out  NCHAN*DATA_W  registered data to the buffers.
buf_we_o  out  NCHAN  per-channel buffer write strobe.
buf_addr_o  out  ADDR_BITS  write address.
busy_o  out  1  high in ARMED, SYNC_WAIT or CAPTURE.
done_o  out  1  capture complete (level).
gap_err_o  out  1  sticky: an enabled channel's tvalid was low during CAPTURE.
len_err_o  out  1  sticky: arm_i was given with length_i==0 or length_i>2^ADDR_BITS.
count_o  out  ADDR_BITS+1  beats written in the current or last capture.

Behaviour:
- Reset (async assert, release synchronous to aclk): state IDLE. All outputs are 0, including buf_tdata_o. The sysref edge register is 0.
- States: IDLE, ARMED, SYNC_WAIT, CAPTURE, DONE.
- IDLE or DONE, arm_i with a legal length:
  - Latch length_i, chan_en_i and sync_mode_i.
  - Clear done_o, gap_err_o and count_o.
  - Go to ARMED on the next cycle.
  - Illegal length: set len_err_o and stay in the current state.
  - len_err_o clears on the next legal arm.
- arm_i in any other state is ignored.
- ARMED, trig_i:
  - Latched sync_mode=0: go to CAPTURE.
  - Latched sync_mode=1: go to SYNC_WAIT.
- trig_i is ignored outside ARMED.
- SYNC_WAIT:
  - sysref_edge = sysref_i & ~sysref_q, where sysref_q is registered every cycle in all states.
  - On the edge cycle, go to CAPTURE on the next cycle.
  - A sysref_i that is still high at trigger time does not count; a fresh rising edge is required.
- CAPTURE, for each cycle:
  - valid_all = &(s_axis_tvalid | ~en_latched).
  - If valid_all: one cycle later buf_we_o = en_latched, buf_tdata_o = s_axis_tdata from the sampled cycle, buf_addr_o = count_o (pre-increment value), and count_o increments.
  - If not valid_all: no write, count_o holds, and gap_err_o sets if any enabled tvalid was high or en_latched!=0.
  - When the write of beat length-1 issues, go to DONE on the same edge as that write. Exactly length writes occur.
  - An all-zero en_latched never writes and stays in CAPTURE until abort.
- Latency: trig_i at cycle T (async mode) gives CAPTURE at T+1. The first possible buf_we_o is at T+2 (data sampled at T+1).
- buf_tdata_o only updates on write cycles. buf_we_o is 0 outside write cycles.
- DONE: done_o=1, busy_o=0. Hold until arm_i (re-arm) or abort_i.
- abort_i in any state: IDLE on the next cycle. buf_we_o is 0 on that next cycle even if a write was pending. done_o clears; count_o holds.
- Priority in a single cycle: abort_i > arm_i > trig_i. A final beat write coincident with abort is dropped.
- Addresses never wrap within a capture: max length 2^ADDR_BITS gives final address 2^ADDR_BITS-1.

Test Plan:
- Async mode, length=16, en=4'b1111, tvalid always 1, trig at T → buf_we_o=4'hF on T+2..T+17, addr 0..15, data matches input delayed 1 cycle, done_o=1 at T+18, count_o=16.
- Sync mode, sysref_i already high at trigger, falling at T+3, rising at T+10 → first write at T+12; no writes before that.
- en=4'b0101, length=8, tvalid[0] drops for 3 cycles mid-capture → 8 writes to channels 0 and 2 only, address contiguous 0..7, gap_err_o=1, capture stretched by 3 cycles.
- Abort on the cycle after the 5th write (length=32) → state IDLE, no further buf_we_o, done_o=0, count_o=5; re-arm+trig gives a fresh capture from addr 0.
- arm_i with length_i=0 and with length_i=2049 → len_err_o=1, state IDLE, busy_o=0; length_i=2048 → writes addr 0..2047 with no wrap, done_o=1.
- Assert aresetn low mid-CAPTURE (asynchronously, between edges) → all outputs 0 immediately; after release, trig_i without arm_i produces no writes.
